// File: rtl/alu_mult_seq_if.sv
// Issue-side handshake for the sequential multiplier.
// The issuer owns start/operands; the multiplier owns ready/done/product.
interface alu_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a_in, b_in,
        input  ready, done, product
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, done, product
    );
endinterface

// File: rtl/alu_mult_seq.sv
// Shift-add 32x32 unsigned multiplier that borrows the shared ALU.
// One ALU add per cycle; the 33-bit sum is shifted into {hi,lo}.
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_mult_seq_if.slave    m,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carryout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;
    logic             ready_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            count   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m.start) begin
                        hi      <= '0;
                        lo      <= m.b_in;
                        mcand   <= m.a_in;
                        count   <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // carry lands in hi's MSB, sum LSB shifts into lo
                    {hi, lo} <= {alu_carryout, alu_out, lo[WIDTH-1:1]};
                    count    <= count + CW'(1);
                    if (count == LAST) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign m.ready   = ready_q;
    assign m.done    = done_q;
    assign m.product = {hi, lo};

    // ALU sees zero on b outside RUN so it idles harmlessly
    assign alu_a   = hi;
    assign alu_b   = (state == RUN && lo[0]) ? mcand : '0;
    assign alu_cmd = 3'd0;
endmodule
